// File: rtl/line_window3x3.sv
// 3x3 neighbourhood window generator over a raster-order gray pixel stream, two line buffers deep.
// Define LINE_WINDOW_EOF_EN to add eof_o, which flags the last window of each frame.
module line_window3x3_row #(
    parameter int WIDTH_P = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 shift_i,
    input  logic [WIDTH_P-1:0]   pix_i,
    output logic [3*WIDTH_P-1:0] taps_o
);
    // Tap 0 (low bits) is the oldest column; new pixels enter at tap 2.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)      taps_o <= '0;
        else if (shift_i) taps_o <= {pix_i, taps_o[3*WIDTH_P-1:WIDTH_P]};
    end
endmodule

module line_window3x3 #(
    parameter int WIDTH_P      = 8,
    parameter int IMG_WIDTH_P  = 640,
    parameter int IMG_HEIGHT_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [9*WIDTH_P-1:0] window_o
`ifdef LINE_WINDOW_EOF_EN
    ,
    output logic                 eof_o
`endif
);
    localparam int CW = $clog2(IMG_WIDTH_P);
    localparam int RW = $clog2(IMG_HEIGHT_P);

    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic                      accept;
    logic                      last_col;
    logic                      last_row;
    logic [2:0][WIDTH_P-1:0]   new_col;
    logic [WIDTH_P-1:0]        lb0 [IMG_WIDTH_P];
    logic [WIDTH_P-1:0]        lb1 [IMG_WIDTH_P];

    assign ready_o  = ~valid_o | ready_i;
    assign accept   = valid_i & ready_o;
    assign last_col = (col == CW'(IMG_WIDTH_P - 1));
    assign last_row = (row == RW'(IMG_HEIGHT_P - 1));
    // Index 0 feeds the top (oldest) window row.
    assign new_col  = {data_i, lb1[col], lb0[col]};

    // Line buffers carry no reset; rows 0-1 of every frame refill them before any window is valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= data_i;
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        line_window3x3_row #(.WIDTH_P(WIDTH_P)) u_row (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .shift_i (accept),
            .pix_i   (new_col[gr]),
            .taps_o  (window_o[gr*3*WIDTH_P +: 3*WIDTH_P])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col     <= '0;
            row     <= '0;
            valid_o <= 1'b0;
        end else begin
            if (accept) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
            end
            // Column >= 2 masks the stale columns left in the shift regs at a row start.
            if (accept)       valid_o <= (row >= RW'(2)) && (col >= CW'(2));
            else if (ready_i) valid_o <= 1'b0;
        end
    end

`ifdef LINE_WINDOW_EOF_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)      eof_o <= 1'b0;
        else if (accept)  eof_o <= last_row && last_col;
        else if (ready_i) eof_o <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_line_window3x3.sv
// Bench for line_window3x3 on a 4x4 image: table vectors, hold/reset sequences, random gaps and backpressure.
module tb_line_window3x3;
    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 4;
`ifdef LINE_WINDOW_EOF_EN
    localparam bit EOF_EN = 1'b1;
`else
    localparam bit EOF_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn, valid_i, ready_o, valid_o, ready_i;
    logic [W-1:0]   data_i;
    logic [9*W-1:0] window_o;
    logic           eof;
`ifdef LINE_WINDOW_EOF_EN
    logic           eof_o;
    assign eof = eof_o;
`else
    assign eof = 1'b0;
`endif

    line_window3x3 #(.WIDTH_P(W), .IMG_WIDTH_P(IW), .IMG_HEIGHT_P(IH)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .window_o (window_o)
`ifdef LINE_WINDOW_EOF_EN
        ,
        .eof_o    (eof_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int             r;
        int             c;
        logic [9*W-1:0] win;
        logic           eof;
    } vec_t;

    vec_t        tbl [4];
    int          vectors = 0;
    int          miscompares = 0;
    logic [72:0] got [$];
    logic [72:0] exp [$];
    logic [7:0]  img [IH][IW];
    bit          rnd_ready = 1'b0;

    // A window is consumed on the next rising edge when valid_o & ready_i hold at the falling edge.
    always @(negedge clk) if (rstn && valid_o && ready_i) got.push_back({eof, window_o});

    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) ready_i = 1'($urandom_range(1, 0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [71:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [71:0] w;
        w = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        return w;
    endfunction

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic fill_img(input bit rnd);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = rnd ? 8'($urandom) : 8'(16 * r + c);
    endtask

    // Reference: every fully-interior 3x3 neighbourhood of the frame, in raster order.
    task automatic model_frame();
        logic [71:0] w;
        for (int r = 2; r < IH; r++)
            for (int c = 2; c < IW; c++) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w[(3*dr+dc)*8 +: 8] = img[r-2+dr][c-2+dc];
                exp.push_back({(r == IH-1 && c == IW-1) && EOF_EN, w});
            end
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        bit acc;
        acc = 1'b0;
        while ($urandom_range(99, 0) < gap) begin
            valid_i = 1'b0;
            @(posedge clk); #1;
        end
        valid_i = 1'b1;
        data_i  = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = ready_o;
            @(posedge clk); #1;
        end
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: pixel %0d never accepted", d);
        end
        valid_i = 1'b0;
    endtask

    task automatic drain();
        rnd_ready = 1'b0;
        ready_i   = 1'b1;
        valid_i   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_q(input string name);
        chk({name, " count"}, 73'(got.size()), 73'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
        got.delete();
        exp.delete();
    endtask

    task automatic hold(input bit last, input logic [7:0] nxt);
        logic [71:0] w;
        w       = window_o;
        ready_i = 1'b0;
        valid_i = !last;
        data_i  = nxt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3 hold valid", 73'(valid_o), 73'(1));
            chk("t3 hold window", 73'(window_o), 73'(w));
            chk("t3 hold ready_o", 73'(ready_o), 73'(0));
            chk("t3 hold eof", 73'(eof), 73'(last && EOF_EN));
        end
        ready_i = 1'b1;
        valid_i = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2, 2, w9( 0,  1,  2, 16, 17, 18, 32, 33, 34), 1'b0};
        tbl[1] = '{2, 3, w9( 1,  2,  3, 17, 18, 19, 33, 34, 35), 1'b0};
        tbl[2] = '{3, 2, w9(16, 17, 18, 32, 33, 34, 48, 49, 50), 1'b0};
        tbl[3] = '{3, 3, w9(17, 18, 19, 33, 34, 35, 49, 50, 51), EOF_EN};

        rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid_o", 73'(valid_o), 73'(0));
        chk("reset window_o", 73'(window_o), 73'(0));
        chk("reset ready_o", 73'(ready_o), 73'(1));
        chk("reset eof", 73'(eof), 73'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        // Test 1: one frame at full rate, cycle-exact against the table.
        fill_img(1'b0); model_frame();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                send(img[r][c], 0);
                chk("t1 valid_o", 73'(valid_o), 73'(r >= 2 && c >= 2));
                for (int k = 0; k < 4; k++)
                    if (tbl[k].r == r && tbl[k].c == c) begin
                        chk("t1 window", 73'(window_o), 73'(tbl[k].win));
                        chk("t1 eof", 73'(eof), 73'(tbl[k].eof));
                    end
            end
        drain(); compare_q("t1 seq");

        // Test 2: 50% input gaps.
        fill_img(1'b0); model_frame();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) send(img[r][c], 50);
        drain(); compare_q("t2 gaps");

        // Test 3: output backpressure on the first and last windows.
        fill_img(1'b0); model_frame();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                send(img[r][c], 0);
                if (r == 2 && c == 2) hold(1'b0, img[2][3]);
                if (r == IH-1 && c == IW-1) hold(1'b1, 8'h00);
            end
        drain(); compare_q("t3 backpressure");

        // Test 4: two back-to-back frames, random data, gaps and random ready_i.
        rnd_ready = 1'b1;
        fill_img(1'b1); model_frame();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) send(img[r][c], 30);
        fill_img(1'b0); model_frame();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) send(img[r][c], 0);
        drain(); compare_q("t4 two frames");

        // Test 5: reset after pixel (2,3), then a fresh frame.
        fill_img(1'b1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < IW; c++) send(img[r][c], 0);
        rstn = 1'b0;
        #1;
        chk("t5 rst valid_o", 73'(valid_o), 73'(0));
        chk("t5 rst window_o", 73'(window_o), 73'(0));
        chk("t5 rst ready_o", 73'(ready_o), 73'(1));
        @(posedge clk); #1;
        rstn = 1'b1;
        got.delete(); exp.delete();
        fill_img(1'b0); model_frame();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) send(img[r][c], 0);
        drain();
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("t5 table window", got[k], {tbl[k].eof, tbl[k].win});
        compare_q("t5 after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
